// File: rtl/countdown_arbiter.sv
// Two-requester round-robin arbiter that sequences a shared external down counter
// through load/run/complete phases and returns a one-cycle done pulse to the owner.
module countdown_arbiter #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req,
   input  logic [W-1:0] len0,
   input  logic [W-1:0] len1,
   output logic [1:0]   gnt,
   output logic [1:0]   done,
   output logic         busy,
   output logic         ctr_rst,
   output logic [W-1:0] ctr_init,
   input  logic [W-1:0] ctr_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t         state_reg, state_next;
   logic           owner_reg, owner_next;    // also serves as last_owner between services
   logic [W-1:0]   len_q_reg, len_q_next;
   logic           winner;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         owner_reg <= 1'b1;
         len_q_reg <= '0;
      end else begin
         state_reg <= state_next;
         owner_reg <= owner_next;
         len_q_reg <= len_q_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      owner_next = owner_reg;
      len_q_next = len_q_reg;
      winner     = owner_reg;
      case (state_reg)
         IDLE: begin
            // On contention the requester that did not win last time takes the grant
            if (|req) begin
               winner     = (req == 2'b11) ? ~owner_reg : req[1];
               owner_next = winner;
               len_q_next = winner ? len1 : len0;
               state_next = LOAD;
            end
         end
         LOAD: begin
            if (!req[owner_reg])
               state_next = IDLE;
            else
               state_next = RUN;
         end
         RUN: begin
            // Withdrawal outranks completion: an aborted service never pulses done
            if (!req[owner_reg])
               state_next = IDLE;
            else if (ctr_count == '0)
               state_next = DONE;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Grant and done are decoded purely from registered state, never from req
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         localparam logic ID = (gi == 1);
         assign gnt[gi]  = (state_reg != IDLE) && (owner_reg == ID);
         assign done[gi] = (state_reg == DONE) && (owner_reg == ID);
      end
   endgenerate

   assign busy     = (state_reg != IDLE);
   assign ctr_rst  = (state_reg != RUN);
   assign ctr_init = ((state_reg == LOAD) || (state_reg == RUN)) ? len_q_reg : '0;

endmodule
